timer_irq_unit: RTL and testbench

Memory-mapped machine-timer and external-interrupt aggregator sitting directly upstream of the SCPU `ext_int` input. Holds a 64-bit free-running `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register, and a synchronised external interrupt source. It merges both into one registered interrupt request that drives the CPU's `ext_int`. The CPU programs it as a slave on the data-memory bus, through the address decoder next to `my_data_memory`.

---
 rtl/timer_irq_unit.sv | 151 +++++++++++++++
 tb/tb_timer_irq_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_unit.sv
`timescale 1ns/1ps
// timer_irq_unit
//   Machine timer (64-bit mtime with 8-bit prescaler, 64-bit mtimecmp) plus a synchronised
//   external interrupt source, merged into one registered interrupt request for the CPU.
//
//   Build option: define IRQ_EDGE_EN for a sticky, write-1-to-clear edge-detected external
//   pending bit. With it undefined, the external pending bit is the synchronised level.
//
// Ports
//   clk      system clock, all state on the rising edge
//   rst      synchronous active-high reset
//   sel      slave select from the bus decoder
//   we       write strobe, qualified by sel
//   addr     word offset (bus address bits [4:2])
//   wdata    write data
//   rdata    read data, combinational; 0 unless sel & ~we
//   irq_src  asynchronous external interrupt source
//   irq_out  registered interrupt request to CPU ext_int
module timer_irq_unit #(
  parameter int unsigned SYNC_STAGES = 2  // legal values 2..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        irq_src,
  output logic        irq_out
);

  localparam logic [2:0] AddrMtimeLo    = 3'd0;
  localparam logic [2:0] AddrMtimeHi    = 3'd1;
  localparam logic [2:0] AddrMtimecmpLo = 3'd2;
  localparam logic [2:0] AddrMtimecmpHi = 3'd3;
  localparam logic [2:0] AddrCtrl       = 3'd4;
  localparam logic [2:0] AddrPending    = 3'd5;

  logic [31:0]            mtime_lo_q, mtime_hi_q, mtime_lo_d, mtime_hi_d;
  logic [31:0]            mtimecmp_lo_q, mtimecmp_hi_q;
  logic                   timer_en_q, timer_ie_q, ext_ie_q;
  logic [7:0]             prescale_q, pcnt_q, pcnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   ep;
  logic                   tp;
  logic                   irq_q;
  logic                   wr;
  logic                   tick;
  logic [63:0]            mtime_inc;

  assign wr        = sel & we;
  assign tick      = timer_en_q & (pcnt_q == prescale_q);
  assign mtime_inc = {mtime_hi_q, mtime_lo_q} + 64'd1;
  assign tp        = {mtime_hi_q, mtime_lo_q} >= {mtimecmp_hi_q, mtimecmp_lo_q};
  assign s_sync    = sync_q[SYNC_STAGES-1];
  assign irq_out   = irq_q;

  // A bus write to either mtime half wins over the tick; the other half holds with no carry.
  always_comb begin
    mtime_lo_d = mtime_lo_q;
    mtime_hi_d = mtime_hi_q;
    if (wr && addr == AddrMtimeLo) begin
      mtime_lo_d = wdata;
    end else if (wr && addr == AddrMtimeHi) begin
      mtime_hi_d = wdata;
    end else if (tick) begin
      {mtime_hi_d, mtime_lo_d} = mtime_inc;
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if (wr && addr == AddrCtrl) begin
      pcnt_d = 8'd0;
    end else if (timer_en_q) begin
      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_lo_q    <= 32'd0;
      mtime_hi_q    <= 32'd0;
      mtimecmp_lo_q <= 32'hFFFF_FFFF;
      mtimecmp_hi_q <= 32'hFFFF_FFFF;
      timer_en_q    <= 1'b0;
      timer_ie_q    <= 1'b0;
      ext_ie_q      <= 1'b0;
      prescale_q    <= 8'd0;
      pcnt_q        <= 8'd0;
      sync_q        <= '0;
      irq_q         <= 1'b0;
    end else begin
      mtime_lo_q <= mtime_lo_d;
      mtime_hi_q <= mtime_hi_d;
      pcnt_q     <= pcnt_d;
      if (wr && addr == AddrMtimecmpLo) mtimecmp_lo_q <= wdata;
      if (wr && addr == AddrMtimecmpHi) mtimecmp_hi_q <= wdata;
      if (wr && addr == AddrCtrl) begin
        timer_en_q <= wdata[0];
        timer_ie_q <= wdata[1];
        ext_ie_q   <= wdata[2];
        prescale_q <= wdata[15:8];
      end
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      irq_q  <= (tp & timer_ie_q) | (ep & ext_ie_q);
    end
  end

`ifdef IRQ_EDGE_EN
  logic s_prev_q;
  logic ep_q;

  assign ep = ep_q;

  // Set has priority over a write-1-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q <= 1'b0;
      ep_q     <= 1'b0;
    end else begin
      s_prev_q <= s_sync;
      if (s_sync && !s_prev_q) begin
        ep_q <= 1'b1;
      end else if (wr && addr == AddrPending && wdata[1]) begin
        ep_q <= 1'b0;
      end
    end
  end
`else
  assign ep = s_sync;
`endif

  always_comb begin
    rdata = 32'd0;
    if (sel && !we) begin
      case (addr)
        AddrMtimeLo:    rdata = mtime_lo_q;
        AddrMtimeHi:    rdata = mtime_hi_q;
        AddrMtimecmpLo: rdata = mtimecmp_lo_q;
        AddrMtimecmpHi: rdata = mtimecmp_hi_q;
        AddrCtrl:       rdata = {16'd0, prescale_q, 5'd0, ext_ie_q, timer_ie_q, timer_en_q};
        AddrPending:    rdata = {30'd0, ep, tp};
        default:        rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
`timescale 1ns/1ps
module tb_timer_irq_unit;

  localparam int unsigned SyncStages = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq_src;
  logic        irq_out;

  always #5 clk = ~clk;

  timer_irq_unit #(.SYNC_STAGES(SyncStages)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_src (irq_src),
    .irq_out (irq_out)
  );

  // Scoreboard queues: one entry per bus cycle.
  string       name_q[$];
  logic [31:0] rd_q[$];
  logic        irq_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Behavioural reference model.
  logic [63:0] m_time, m_cmp;
  bit          m_en, m_tie, m_eie, m_ep, m_irq;
  int          m_pre, m_pcnt;
  bit          m_hist [0:3];  // m_hist[i]: irq_src as sampled i+1 edges ago
  bit          cur_src;

  function automatic bit m_ep_val();
`ifdef IRQ_EDGE_EN
    return m_ep;
`else
    return m_hist[SyncStages-1];
`endif
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a);
    logic [7:0] p;
    p = m_pre[7:0];
    case (a)
      3'd0:    return m_time[31:0];
      3'd1:    return m_time[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {16'd0, p, 5'd0, m_eie, m_tie, m_en};
      3'd5:    return {30'd0, m_ep_val(), m_time >= m_cmp};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_time = 64'd0;
    m_cmp  = '1;
    m_en   = 0; m_tie = 0; m_eie = 0; m_ep = 0; m_irq = 0;
    m_pre  = 0; m_pcnt = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  endtask

  task automatic m_step(bit s, bit w, logic [2:0] a, logic [31:0] d, bit src);
    bit wr, tick, rise, irq_next;
    wr       = s && w;
    tick     = m_en && (m_pcnt == m_pre);
    rise     = m_hist[SyncStages-1] && !m_hist[SyncStages];
    irq_next = ((m_time >= m_cmp) && m_tie) || (m_ep_val() && m_eie);
    if (wr && a == 3'd0)      m_time[31:0]  = d;
    else if (wr && a == 3'd1) m_time[63:32] = d;
    else if (tick)            m_time        = m_time + 64'd1;
    if (wr && a == 3'd4)      m_pcnt = 0;
    else if (m_en)            m_pcnt = tick ? 0 : m_pcnt + 1;
    if (wr && a == 3'd2) m_cmp[31:0]  = d;
    if (wr && a == 3'd3) m_cmp[63:32] = d;
    if (wr && a == 3'd4) begin
      m_en = d[0]; m_tie = d[1]; m_eie = d[2]; m_pre = int'(d[15:8]);
    end
`ifdef IRQ_EDGE_EN
    if (rise) m_ep = 1;
    else if (wr && a == 3'd5 && d[1]) m_ep = 0;
`endif
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = src;
    m_irq = irq_next;
  endtask

  // One bus cycle: drive, push expectation, clock, advance model.
  task automatic cycle(bit s, bit w, logic [2:0] a, logic [31:0] d, string nm,
                       bit use_const = 0, logic [31:0] cval = 32'd0);
    sel = s; we = w; addr = a; wdata = d; irq_src = cur_src;
    name_q.push_back(nm);
    rd_q.push_back(use_const ? cval : ((s && !w) ? m_read(a) : 32'd0));
    irq_q.push_back(m_irq);
    @(posedge clk);
    m_step(s, w, a, d, cur_src);
    #1;
  endtask

  task automatic wr_reg(logic [2:0] a, logic [31:0] d);
    cycle(1, 1, a, d, "write");
  endtask

  task automatic rd_const(logic [2:0] a, logic [31:0] v, string nm);
    cycle(1, 0, a, 32'd0, nm, 1, v);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 32'd0, "idle");
  endtask

  // Reset held for two edges; optionally with a concurrent write that must be discarded.
  task automatic do_reset(bit with_write);
    sel = with_write; we = with_write; addr = 3'd0; wdata = 32'h1234_5678;
    irq_src = cur_src; rst = 1'b1;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    rst = 1'b0; sel = 1'b0; we = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queued expectation.
  initial begin
    string       nm;
    logic [31:0] er;
    logic        ei;
    forever begin
      @(negedge clk);
      if (name_q.size() > 0) begin
        nm = name_q.pop_front();
        er = rd_q.pop_front();
        ei = irq_q.pop_front();
        vectors += 2;
        if (rdata !== er) begin
          miscompares++;
          $display("FAIL %s rdata: got %h expected %h (t=%0t)", nm, rdata, er, $time);
        end
        if (irq_out !== ei) begin
          miscompares++;
          $display("FAIL %s irq_out: got %b expected %b (t=%0t)", nm, irq_out, ei, $time);
        end
      end
    end
  end

  initial begin
    logic [31:0] ep_sticky;
    cur_src = 0;
    sel = 0; we = 0; addr = 0; wdata = 0; irq_src = 0; rst = 0;
    m_reset();
    @(posedge clk); #1;
    do_reset(0);

    // Reset state
    rd_const(3'd0, 32'd0, "reset_mtime_lo");
    rd_const(3'd3, 32'hFFFF_FFFF, "reset_mtimecmp_hi");
    rd_const(3'd4, 32'd0, "reset_ctrl");

    // Prescaler: prescale=3 gives one increment every 4 clocks
    wr_reg(3'd4, 32'h0000_0301);
    idle(40);
    rd_const(3'd0, 32'd10, "prescale_count");
    wr_reg(3'd4, 32'h0000_0300);
    idle(20);
    rd_const(3'd0, 32'd10, "disabled_hold");

    // Carry into the high word and compare
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd0, 32'hFFFF_FFFE);
    wr_reg(3'd3, 32'd1);
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd4, 32'h0000_0003);
    idle(2);
    rd_const(3'd1, 32'd1, "carry_hi");
    rd_const(3'd5, 32'd1, "tp_set");
    idle(2);
    wr_reg(3'd3, 32'd2);
    idle(2);

    // Write wins over a same-cycle increment
    wr_reg(3'd0, 32'h55);
    rd_const(3'd0, 32'h55, "collide_written");
    rd_const(3'd0, 32'h56, "collide_next");

    // External interrupt: 3-cycle pulse
    wr_reg(3'd4, 32'h0000_0004);
    cur_src = 1; idle(3);
    cur_src = 0; idle(6);
`ifdef IRQ_EDGE_EN
    ep_sticky = 32'h2;
`else
    ep_sticky = 32'h0;
`endif
    rd_const(3'd5, ep_sticky, "ep_after_pulse");
    wr_reg(3'd5, 32'h2);
    idle(1);
    rd_const(3'd5, 32'h0, "ep_cleared");
    // New edge detected on the same edge as a clear
    cur_src = 1; idle(2);
    wr_reg(3'd5, 32'h2);
    rd_const(3'd5, 32'h2, "ep_set_wins");
    cur_src = 0; idle(4);

    // Toggling source
    for (int i = 0; i < 12; i++) begin
      cur_src = ~cur_src;
      idle(int'($urandom_range(1, 5)));
      wr_reg(3'd5, 32'h2);
    end
    cur_src = 0; idle(5);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [2:0]  a;
      logic [31:0] d;
      if (i == 1500) do_reset(1);
      if ($urandom_range(0, 7) == 0) cur_src = ~cur_src;
      r = int'($urandom_range(0, 99));
      a = 3'($urandom_range(0, 7));
      if (r < 40) begin
        cycle(0, 1'($urandom_range(0, 1)), a, $urandom, "rand_unsel");
      end else if (r < 80) begin
        cycle(1, 0, a, $urandom, "rand_read");
      end else begin
        case (a)
          3'd0, 3'd2: d = 32'($urandom_range(0, 300)) | ($urandom_range(0, 3) == 0 ? 32'hFFFF_FF00 : 32'd0);
          3'd1, 3'd3: d = 32'($urandom_range(0, 1));
          3'd4: d = {$urandom_range(0, 1) ? $urandom : 32'd0} & 32'hFFFF_00F8
                    | {16'd0, 8'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7))};
          default: d = $urandom;
        endcase
        cycle(1, 1, a, d, "rand_write");
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
